// File: rtl/pinwheel_uart_tx.sv
// pinwheel_uart_tx: bus-mapped 8N1 serial console transmitter.
// TXDATA writes fill a small FIFO that a start/data/stop FSM drains
// onto tx. A status word (level, empty, full, busy, overflow) is
// exposed on rdata for the top-level read mux.
module pinwheel_uart_tx #(
    parameter logic [3:0] TAG          = 4'h4,
    parameter int         DEPTH        = 8,
    parameter int         CLKS_PER_BIT = 16
) (
    input  logic        clock,
    input  logic        reset_in,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_wren,
    output logic [31:0] rdata,
    output logic        tx
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [AW:0]   PTR_ONE    = (AW + 1)'(32'd1);
    localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE   = BW'(32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [BW-1:0] baud_r, baud_s;
    logic [2:0]    bit_r, bit_s;
    logic [7:0]    shift_r, shift_s;
    logic          tx_r, tx_s;
    logic          pop_s;
    logic          baud_end_s;

    logic [AW:0]   wptr_r, rptr_r;
    logic [AW:0]   level_s;
    logic          empty_s, full_s;
    logic [7:0]    mem_r [DEPTH];
    logic [7:0]    head_s;

    logic          sel_s, push_req_s, push_ok_s;
    logic          ovf_r, ovf_set_s, ovf_clr_s;
    logic          busy_s;
    logic          unused_bits_s;

    // Bus decode: tag selects the block, word offset selects the register.
    assign sel_s      = bus_wren && (bus_addr[31:28] == TAG);
    assign push_req_s = sel_s && (bus_addr[3:2] == 2'd0);
    assign ovf_clr_s  = sel_s && (bus_addr[3:2] == 2'd1) && bus_wdata[0];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level_s  = wptr_r - rptr_r;
    assign empty_s  = (level_s == {(AW + 1){1'b0}});
    assign full_s   = (level_s == LEVEL_FULL);
    assign head_s   = mem_r[rptr_r[AW-1:0]];

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign push_ok_s = push_req_s && (!full_s || pop_s);
    assign ovf_set_s = push_req_s && full_s && !pop_s;

    assign baud_end_s = (baud_r == BAUD_LAST);
    assign busy_s     = (state_r != ST_IDLE);

    assign rdata = {20'd0, ovf_r, busy_s, full_s, empty_s, 8'(level_s)};
    assign tx    = tx_r;

    // Address and data bits outside the decoded fields are don't-care.
    assign unused_bits_s = ^{bus_addr[27:4], bus_addr[1:0], bus_wdata[31:8]};

    // FIFO storage; contents are only meaningful between rptr and wptr.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wptr_r[AW-1:0]] <= bus_wdata[7:0];
        end
    end

    // FIFO read/write pointers.
    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) begin
            wptr_r <= {(AW + 1){1'b0}};
            rptr_r <= {(AW + 1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
        end
    end

    // Sticky overflow flag; a new drop in the same cycle beats a clear.
    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) begin
            ovf_r <= 1'b0;
        end else if (ovf_set_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr_s) begin
            ovf_r <= 1'b0;
        end
    end

    // Transmitter state register; tx is registered so it never glitches.
    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) begin
            state_r <= ST_IDLE;
            baud_r  <= {BW{1'b0}};
            bit_r   <= 3'd0;
            shift_r <= 8'd0;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            tx_r    <= tx_s;
        end
    end

    // Next-state logic: frame sequencing, bit timing and FIFO pops.
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        pop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    shift_s = head_s;
                    state_s = ST_START;
                    baud_s  = {BW{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    state_s = ST_DATA;
                    baud_s  = {BW{1'b0}};
                    bit_s   = 3'd0;
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    baud_s  = {BW{1'b0}};
                    shift_s = {1'b0, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (baud_end_s) begin
                    baud_s = {BW{1'b0}};
                    if (!empty_s) begin
                        // Chain straight into the next frame, no idle gap.
                        pop_s   = 1'b1;
                        shift_s = head_s;
                        state_s = ST_START;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                baud_s  = {BW{1'b0}};
                bit_s   = 3'd0;
            end
        endcase
    end

    // Line level for the upcoming cycle, derived from the next state.
    always_comb begin
        tx_s = 1'b1;
        case (state_s)
            ST_IDLE:  tx_s = 1'b1;
            ST_START: tx_s = 1'b0;
            ST_DATA:  tx_s = shift_s[0];
            ST_STOP:  tx_s = 1'b1;
            default:  tx_s = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_pinwheel_uart_tx.sv
// tb_pinwheel_uart_tx: randomized and directed stimulus against a
// frame-level reference model; a monitor decodes tx and compares
// each frame with the queue of expected frames.
module tb_pinwheel_uart_tx;

    localparam logic [3:0] TAG   = 4'h4;
    localparam int         DEPTH = 8;
    localparam int         CPB   = 4;
    localparam int         FRAME = 10 * CPB;

    logic        clock = 1'b0;
    logic        reset_in;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_wren;
    logic [31:0] rdata;
    logic        tx;

    pinwheel_uart_tx #(.TAG(TAG), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clock(clock), .reset_in(reset_in), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wren(bus_wren), .rdata(rdata), .tx(tx)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    // Edge counter shared by driver, model and monitor.
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] data;
        int         start;
    } frame_t;

    // Reference model state.
    logic [7:0] fifo_q[$];
    frame_t     exp_q[$];
    logic       m_ovf = 1'b0;
    int         next_free = 0;
    int         last_pop_t = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_addr(input logic [3:0] tag, input logic [1:0] off);
        return {tag, 24'd0, off, 2'b00};
    endfunction

    function automatic logic [31:0] model_rdata();
        logic [31:0] r;
        int lvl;
        lvl = fifo_q.size();
        r = 32'd0;
        r[7:0] = 8'(lvl);
        r[8]   = (lvl == 0);
        r[9]   = (lvl == DEPTH);
        r[10]  = (cyc < next_free);
        r[11]  = m_ovf;
        return r;
    endfunction

    // Apply the block's rules for one clock edge t.
    task automatic model_edge(input int t, input logic wr, input logic [31:0] a, input logic [31:0] d);
        bit was_full, pop, sel, set_ovf;
        frame_t f;
        was_full = (fifo_q.size() == DEPTH);
        pop = (fifo_q.size() > 0) && (t >= next_free);
        set_ovf = 1'b0;
        if (pop) begin
            f.data = fifo_q.pop_front();
            f.start = t;
            exp_q.push_back(f);
            next_free = t + FRAME;
            last_pop_t = t;
        end
        sel = wr && (a[31:28] == TAG);
        if (sel && a[3:2] == 2'd0) begin
            if (!was_full || pop) fifo_q.push_back(d[7:0]);
            else set_ovf = 1'b1;
        end
        if (set_ovf) m_ovf = 1'b1;
        else if (sel && a[3:2] == 2'd1 && d[0]) m_ovf = 1'b0;
    endtask

    task automatic step(input logic wr, input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        bus_wren = wr;
        bus_addr = a;
        bus_wdata = d;
        model_edge(cyc + 1, wr, a, d);
        @(posedge clock);
        #1;
        chk("status", rdata, model_rdata());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0);
    endtask

    task automatic push(input logic [7:0] b);
        step(1'b1, mk_addr(TAG, 2'd0), {24'hABCDEF, b});
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((fifo_q.size() > 0 || cyc < next_free) && guard < 5000) begin
            idle(1);
            guard++;
        end
        total++;
        if (guard >= 5000) begin
            bad++;
            $display("FAIL drain_timeout cycle=%0d got=%0d want=0", cyc, fifo_q.size());
        end
        idle(3);
    endtask

    // Monitor: decodes tx frames and compares with the expected queue.
    logic       mon_active = 1'b0;
    logic       mon_skip   = 1'b0;
    int         mon_start  = 0;
    logic [7:0] mon_byte   = 8'd0;

    always @(negedge clock) begin
        int off;
        int k;
        logic eb;
        frame_t f;
        if (reset_in) begin
            mon_active = 1'b0;
        end else if (mon_active) begin
            off = cyc - mon_start;
            k = off / CPB;
            if (!mon_skip) begin
                if (k == 0) eb = 1'b0;
                else if (k == 9) eb = 1'b1;
                else eb = mon_byte[k-1];
                chk("tx_bit", {31'd0, tx}, {31'd0, eb});
            end
            if (off >= FRAME - 1) mon_active = 1'b0;
        end else if (tx === 1'b0) begin
            mon_active = 1'b1;
            mon_start = cyc;
            if (exp_q.size() == 0) begin
                mon_skip = 1'b1;
                chk("unexpected_frame", 32'd1, 32'd0);
            end else begin
                mon_skip = 1'b0;
                f = exp_q.pop_front();
                mon_byte = f.data;
                chk("frame_start", cyc, f.start);
            end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].start) begin
            f = exp_q.pop_front();
            chk("missing_frame", cyc, f.start);
        end
    end

    initial begin
        logic [31:0] a;
        int r;
        reset_in = 1'b1;
        bus_wren = 1'b0;
        bus_addr = 32'd0;
        bus_wdata = 32'd0;
        #12;
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_rdata", rdata, 32'h0000_0100);
        @(negedge clock);
        reset_in = 1'b0;
        idle(3);

        // Single byte.
        push(8'h55);
        idle(FRAME + 5);

        // Back-to-back frames with no gap.
        push(8'h41);
        push(8'h42);
        idle(5);
        chk("b2b_level_frame1", rdata, 32'h0000_0401);
        drain();

        // Overflow: ten writes into an eight-entry FIFO.
        for (int i = 0; i < 10; i++) push(8'(i));
        chk("overflow_status", rdata, 32'h0000_0E08);
        step(1'b1, mk_addr(TAG, 2'd1), 32'd1);
        chk("overflow_clear", rdata & 32'h0000_0800, 32'd0);
        drain();

        // Push into a full FIFO on the cycle of a STOP->START pop.
        for (int i = 0; i < DEPTH + 1; i++) push(8'hA0 + 8'(i));
        while (cyc < next_free - 1) idle(1);
        push(8'h5A);
        chk("full_pop_status", rdata, 32'h0000_0608);
        drain();

        // Decode: foreign tags and unused offsets leave everything alone.
        step(1'b1, mk_addr(4'h8, 2'd0), 32'h11);
        step(1'b1, mk_addr(4'hF, 2'd0), 32'h22);
        step(1'b1, mk_addr(TAG + 4'h1, 2'd0), 32'h33);
        step(1'b1, mk_addr(TAG, 2'd2), 32'h44);
        step(1'b1, mk_addr(TAG, 2'd3), 32'h55);
        chk("decode_idle", rdata, 32'h0000_0100);
        idle(5);

        // Reset during DATA bit 3 of an all-zero byte.
        push(8'h00);
        push(8'h11);
        push(8'h22);
        while (cyc < last_pop_t + 4 * CPB + 1) idle(1);
        #2;
        reset_in = 1'b1;
        #1;
        chk("midreset_tx", {31'd0, tx}, 32'd1);
        chk("midreset_rdata", rdata, 32'h0000_0100);
        fifo_q.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        next_free = 0;
        repeat (2) @(negedge clock);
        reset_in = 1'b0;
        idle(FRAME * 2);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                push(8'($urandom));
            end else if (r < 10) begin
                step(1'b1, mk_addr(TAG, 2'd1), $urandom);
            end else if (r < 15) begin
                a = $urandom;
                if (r < 12) a[31:28] = TAG;
                step(1'b1, a, $urandom);
            end else begin
                idle(1);
            end
        end
        drain();

        chk("end_queue_empty", exp_q.size(), 32'd0);
        chk("end_monitor_idle", {31'd0, mon_active}, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
